// File: rtl/regfile_sweep_if.sv
// Bus bundle for regfile_sweep: write port, two read ports, sweep request and busy.
//   master : decode/writeback side (drives addresses, write data, clr)
//   slave  : register file side (drives rd_data_a, rd_data_b, busy)
interface regfile_sweep_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              clr;
  logic              busy;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output clr,
    input  rd_data_a, rd_data_b, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  clr,
    output rd_data_a, rd_data_b, busy
  );
endinterface

// File: rtl/regfile_sweep.sv
// 2-read/1-write register file with a clear sweep.
//   elk  : clock, rising edge
//   nrst : synchronous active-high reset (priority over everything)
//   bus  : regfile_sweep_if.slave -- write port, registered read ports A/B,
//          clr sweep request, busy status
// Entry 0 reads as zero; entry SP_IDX resets (and sweeps) to SP_RST.
// Optional macro REGFILE_BYPASS_EN: same-cycle write/sweep data is forwarded
// to a read of the same entry.
//
// state | meaning
// IDLE  | normal operation, writes accepted, clr starts a sweep
// SWEEP | one entry re-initialised per cycle at cnt, writes dropped
module regfile_sweep #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SP_IDX = 29,
  parameter int SP_RST = 252
) (
  input logic          elk,
  input logic          nrst,
  regfile_sweep_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] SP_VAL    = DATA_W'(SP_RST);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sweep_val;
  logic [DATA_W-1:0] rd_next_a;
  logic [DATA_W-1:0] rd_next_b;

  assign sweep_val = (cnt == SP_ADDR) ? SP_VAL : '0;

  always_comb begin
    rd_next_a = (bus.rd_addr_a == '0) ? '0 : mem[bus.rd_addr_a];
    rd_next_b = (bus.rd_addr_b == '0) ? '0 : mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    // Forward the value being written this edge so a read sees it immediately.
    if (bus.rd_addr_a != '0) begin
      if (state == IDLE && bus.wr_en && bus.wr_addr == bus.rd_addr_a)
        rd_next_a = bus.wr_data;
      else if (state == SWEEP && bus.rd_addr_a == cnt)
        rd_next_a = sweep_val;
    end
    if (bus.rd_addr_b != '0) begin
      if (state == IDLE && bus.wr_en && bus.wr_addr == bus.rd_addr_b)
        rd_next_b = bus.wr_data;
      else if (state == SWEEP && bus.rd_addr_b == cnt)
        rd_next_b = sweep_val;
    end
`endif
  end

  always_ff @(posedge elk) begin
    if (nrst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i == SP_IDX) ? SP_VAL : '0;
      state         <= IDLE;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.rd_data_a <= '0;
      bus.rd_data_b <= '0;
    end else begin
      if (bus.rd_en_a) bus.rd_data_a <= rd_next_a;
      if (bus.rd_en_b) bus.rd_data_b <= rd_next_b;

      case (state)
        IDLE: begin
          // A write in the same cycle as clr lands first; the sweep then clears it.
          if (bus.wr_en && bus.wr_addr != '0)
            mem[bus.wr_addr] <= bus.wr_data;
          if (bus.clr) begin
            state    <= SWEEP;
            cnt      <= ADDR_W'(1);
            bus.busy <= 1'b1;
          end
        end
        SWEEP: begin
          // Entry 0 is never swept: it is never written, so it stays zero.
          mem[cnt] <= sweep_val;
          if (cnt == LAST_ADDR) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_sweep.sv
module tb_regfile_sweep;
  logic elk = 1'b0;
  logic nrst = 1'b1;
  always #5 elk = ~elk;

  regfile_sweep_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_sweep #(.DATA_W(32), .ADDR_W(5), .SP_IDX(29), .SP_RST(252)) dut (
    .elk  (elk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          port_b;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en_a;
    logic [4:0]  rd_addr_a;
    logic        rd_en_b;
    logic [4:0]  rd_addr_b;
    bit          chk_a;
    logic [31:0] exp_a;
    bit          chk_b;
    logic [31:0] exp_b;
  } vec_t;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] SAME3 = 32'hA5A5_A5A5;
  localparam logic [31:0] SAME9 = 32'h11;
`else
  localparam logic [31:0] SAME3 = 32'h0;
  localparam logic [31:0] SAME9 = 32'h0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input bit port_b, input logic [31:0] exp, input string name);
    sb_t e;
    e.port_b = port_b;
    e.exp    = exp;
    e.name   = name;
    sb.push_back(e);
  endtask

  // One clock edge, then settle and retire every read that edge performed.
  task automatic tick();
    sb_t e;
    @(posedge elk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, e.port_b ? bus.rd_data_b : bus.rd_data_a, e.exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en_a = 0; bus.rd_addr_a = '0;
    bus.rd_en_b = 0; bus.rd_addr_b = '0;
    bus.clr = 0;
  endtask

  task automatic read(input logic [4:0] a, input logic [31:0] ea,
                      input logic [4:0] b, input logic [31:0] eb, input string name);
    bus.rd_en_a = 1; bus.rd_addr_a = a;
    bus.rd_en_b = 1; bus.rd_addr_b = b;
    push(0, ea, {name, "_a"});
    push(1, eb, {name, "_b"});
    tick();
    bus.rd_en_a = 0; bus.rd_en_b = 0;
  endtask

  vec_t vecs[10];
  int   nb;
  int   guard;

  initial begin
    //         we adr data           ea a   eb b   ca exp_a          cb exp_b
    vecs[0] = '{0, 0, 32'h0,         1, 29, 1, 5,  1, 32'd252,       1, 32'h0};
    vecs[1] = '{1, 7, 32'hDEADBEEF,  0, 0,  0, 0,  0, 32'h0,         0, 32'h0};
    vecs[2] = '{0, 0, 32'h0,         1, 7,  1, 7,  1, 32'hDEADBEEF,  1, 32'hDEADBEEF};
    vecs[3] = '{1, 0, 32'h1234,      1, 0,  0, 0,  1, 32'h0,         0, 32'h0};
    vecs[4] = '{0, 0, 32'h0,         1, 0,  1, 0,  1, 32'h0,         1, 32'h0};
    vecs[5] = '{1, 3, 32'hA5A5A5A5,  1, 3,  0, 0,  1, SAME3,         0, 32'h0};
    vecs[6] = '{0, 0, 32'h0,         1, 3,  0, 0,  1, 32'hA5A5A5A5,  0, 32'h0};
    vecs[7] = '{0, 0, 32'h0,         0, 7,  0, 7,  1, 32'hA5A5A5A5,  1, 32'h0};
    vecs[8] = '{1, 9, 32'h11,        0, 0,  1, 9,  0, 32'h0,         1, SAME9};
    vecs[9] = '{0, 0, 32'h0,         1, 9,  1, 9,  1, 32'h11,        1, 32'h11};

    idle_inputs();
    nrst = 1;
    tick();
    tick();
    nrst = 0;
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_rd_a", bus.rd_data_a, 32'h0);
    check("reset_rd_b", bus.rd_data_b, 32'h0);

    for (int i = 0; i < 10; i++) begin
      bus.wr_en = vecs[i].wr_en; bus.wr_addr = vecs[i].wr_addr; bus.wr_data = vecs[i].wr_data;
      bus.rd_en_a = vecs[i].rd_en_a; bus.rd_addr_a = vecs[i].rd_addr_a;
      bus.rd_en_b = vecs[i].rd_en_b; bus.rd_addr_b = vecs[i].rd_addr_b;
      if (vecs[i].chk_a) push(0, vecs[i].exp_a, $sformatf("vec%0d_a", i));
      if (vecs[i].chk_b) push(1, vecs[i].exp_b, $sformatf("vec%0d_b", i));
      tick();
    end
    idle_inputs();

    // Sweep: busy length, dropped write, partial-progress reads.
    bus.clr = 1;
    tick();
    bus.clr = 0;
    nb = 0;
    guard = 0;
    while (bus.busy && guard < 100) begin
      nb++;
      guard++;
      idle_inputs();
      if (nb == 2) begin
        bus.wr_en = 1; bus.wr_addr = 4; bus.wr_data = 32'h55;
      end
      if (nb == 3) begin
        bus.rd_en_a = 1; bus.rd_addr_a = 9;
        push(0, 32'h11, "sweep_above_cnt");
      end
      if (nb == 10) begin
        bus.rd_en_a = 1; bus.rd_addr_a = 9;
        bus.rd_en_b = 1; bus.rd_addr_b = 7;
        push(0, 32'h0, "sweep_below_cnt_a");
        push(1, 32'h0, "sweep_below_cnt_b");
      end
      tick();
    end
    idle_inputs();
    check("sweep_busy_cycles", nb, 31);
    read(9, 32'h0, 4, 32'h0, "after_sweep_9_4");
    read(29, 32'd252, 3, 32'h0, "after_sweep_29_3");

    // Reset mid-sweep.
    bus.clr = 1;
    tick();
    bus.clr = 0;
    repeat (9) tick();
    check("mid_sweep_busy", {31'b0, bus.busy}, 32'h1);
    nrst = 1;
    tick();
    nrst = 0;
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    bus.wr_en = 1; bus.wr_addr = 2; bus.wr_data = 32'h77;
    tick();
    idle_inputs();
    read(2, 32'h77, 29, 32'd252, "post_abort");

    // clr and write together in IDLE.
    bus.clr = 1; bus.wr_en = 1; bus.wr_addr = 6; bus.wr_data = 32'h99;
    tick();
    idle_inputs();
    check("clr_wr_busy", {31'b0, bus.busy}, 32'h1);
    guard = 0;
    while (bus.busy && guard < 100) begin
      guard++;
      tick();
    end
    check("clr_wr_done", guard, 31);
    read(6, 32'h0, 2, 32'h0, "clr_wr_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
